// File: rtl/marker_centroid_if.sv
// Video-in / marker-out bundle for marker_centroid: pixel stream in, centroid result out.
interface marker_centroid_if;
   logic        de_in;
   logic        hsync_in;
   logic        vsync_in;
   logic [23:0] pixel_in;
   logic [31:0] x;
   logic [31:0] y;
   logic        valid;
   logic        found;
   logic        busy;

   modport master (
      output de_in, hsync_in, vsync_in, pixel_in,
      input  x, y, valid, found, busy
   );

   modport slave (
      input  de_in, hsync_in, vsync_in, pixel_in,
      output x, y, valid, found, busy
   );
endinterface

// File: rtl/marker_centroid.sv
// Thresholds a video stream for a red marker, accumulates hit coordinates per frame and
// divides at frame end to produce the 1-based marker centroid.
module marker_centroid #(
   parameter logic [7:0]  R_MIN   = 8'd200,
   parameter logic [7:0]  G_MAX   = 8'd80,
   parameter logic [7:0]  B_MAX   = 8'd80,
   parameter logic [21:0] MIN_PIX = 22'd16
) (
   input logic               clk,
   input logic               rst,
   marker_centroid_if.slave  bus
);

   typedef enum logic [2:0] {
      StAcc,
      StDivX,
      StDivY,
      StDone,
      StRej
   } state_e;

   state_e      state_q, state_d;

   logic [10:0] x_pos_q, x_pos_d;
   logic [9:0]  y_pos_q, y_pos_d;
   logic        vsync_q;

   logic [31:0] sum_x_q, sum_x_d;
   logic [31:0] sum_y_q, sum_y_d;
   logic [21:0] cnt_q, cnt_d;

   logic [31:0] sum_y_snap_q, sum_y_snap_d;
   logic [21:0] div_q, div_d;
   logic [31:0] dq_q, dq_d;
   logic [21:0] rem_q, rem_d;
   logic [4:0]  bit_q, bit_d;
   logic [10:0] qx_q, qx_d;

   logic [31:0] x_q, x_d;
   logic [31:0] y_q, y_d;
   logic        valid_q, valid_d;
   logic        found_q, found_d;

   logic        pix_hit;
   logic        frame_end;
   logic        accept;

   logic [22:0] shifted;
   logic        take;
   logic [21:0] rem_next;
   logic [31:0] dq_next;

   assign pix_hit = bus.de_in
                    & (bus.pixel_in[23:16] >= R_MIN)
                    & (bus.pixel_in[15:8]  <= G_MAX)
                    & (bus.pixel_in[7:0]   <= B_MAX);

   assign frame_end = bus.vsync_in & ~vsync_q;

   // Raster position; hsync only counts as a line break once pixels were seen on the line.
   always_comb begin
      x_pos_d = x_pos_q;
      y_pos_d = y_pos_q;
      if (bus.vsync_in) begin
         x_pos_d = 11'd1;
         y_pos_d = 10'd1;
      end else if (bus.hsync_in && (x_pos_q != 11'd1)) begin
         x_pos_d = 11'd1;
         y_pos_d = y_pos_q + 10'd1;
      end else if (bus.de_in) begin
         x_pos_d = x_pos_q + 11'd1;
      end
   end

   // A hit in the frame-end cycle seeds the new frame rather than the snapshot.
   always_comb begin
      sum_x_d = sum_x_q;
      sum_y_d = sum_y_q;
      cnt_d   = cnt_q;
      if (frame_end) begin
         sum_x_d = pix_hit ? {21'd0, x_pos_q} : 32'd0;
         sum_y_d = pix_hit ? {22'd0, y_pos_q} : 32'd0;
         cnt_d   = pix_hit ? 22'd1 : 22'd0;
      end else if (pix_hit) begin
         sum_x_d = sum_x_q + {21'd0, x_pos_q};
         sum_y_d = sum_y_q + {22'd0, y_pos_q};
         cnt_d   = cnt_q + 22'd1;
      end
   end

   // One restoring-division step; the remainder always stays below the 22-bit divisor.
   always_comb begin
      shifted  = {rem_q, dq_q[31]};
      take     = (shifted >= {1'b0, div_q});
      rem_next = take ? (shifted[21:0] - div_q) : shifted[21:0];
      dq_next  = {dq_q[30:0], take};
   end

   always_comb begin
      state_d      = state_q;
      sum_y_snap_d = sum_y_snap_q;
      div_d        = div_q;
      dq_d         = dq_q;
      rem_d        = rem_q;
      bit_d        = bit_q;
      qx_d         = qx_q;
      x_d          = x_q;
      y_d          = y_q;
      valid_d      = 1'b0;
      found_d      = found_q;
      accept       = 1'b0;

      unique case (state_q)
         StAcc: begin
            accept = frame_end;
         end
         StDivX: begin
            dq_d  = dq_next;
            rem_d = rem_next;
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
               qx_d    = dq_next[10:0];
               dq_d    = sum_y_snap_q;
               rem_d   = 22'd0;
               state_d = StDivY;
            end
         end
         StDivY: begin
            dq_d  = dq_next;
            rem_d = rem_next;
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
               state_d = StDone;
            end
         end
         StDone: begin
            x_d     = {21'd0, qx_q};
            y_d     = {22'd0, dq_q[9:0]};
            found_d = 1'b1;
            valid_d = 1'b1;
            state_d = StAcc;
            accept  = frame_end;
         end
         StRej: begin
            found_d = 1'b0;
            valid_d = 1'b1;
            state_d = StAcc;
            accept  = frame_end;
         end
         default: begin
            state_d = StAcc;
         end
      endcase

      // Frame ends during a divide are dropped; otherwise the snapshot starts a new job.
      if (accept) begin
         sum_y_snap_d = sum_y_q;
         div_d        = cnt_q;
         dq_d         = sum_x_q;
         rem_d        = 22'd0;
         bit_d        = 5'd0;
         state_d      = (cnt_q < MIN_PIX) ? StRej : StDivX;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StAcc;
         x_pos_q      <= 11'd1;
         y_pos_q      <= 10'd1;
         vsync_q      <= 1'b0;
         sum_x_q      <= 32'd0;
         sum_y_q      <= 32'd0;
         cnt_q        <= 22'd0;
         sum_y_snap_q <= 32'd0;
         div_q        <= 22'd0;
         dq_q         <= 32'd0;
         rem_q        <= 22'd0;
         bit_q        <= 5'd0;
         qx_q         <= 11'd0;
         x_q          <= 32'd0;
         y_q          <= 32'd0;
         valid_q      <= 1'b0;
         found_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_pos_q      <= x_pos_d;
         y_pos_q      <= y_pos_d;
         vsync_q      <= bus.vsync_in;
         sum_x_q      <= sum_x_d;
         sum_y_q      <= sum_y_d;
         cnt_q        <= cnt_d;
         sum_y_snap_q <= sum_y_snap_d;
         div_q        <= div_d;
         dq_q         <= dq_d;
         rem_q        <= rem_d;
         bit_q        <= bit_d;
         qx_q         <= qx_d;
         x_q          <= x_d;
         y_q          <= y_d;
         valid_q      <= valid_d;
         found_q      <= found_d;
      end
   end

   assign bus.x     = x_q;
   assign bus.y     = y_q;
   assign bus.valid = valid_q;
   assign bus.found = found_q;
   assign bus.busy  = (state_q == StDivX) || (state_q == StDivY);

endmodule

// File: tb/tb_marker_centroid.sv
// Drives two marker_centroid instances (default threshold and MIN_PIX=1) from one stream and
// checks both against a frame-level model every cycle, plus literal centroid expectations.
module tb_marker_centroid;

   logic        clk = 1'b0;
   logic        rst;
   logic        de, hs, vs;
   logic [23:0] pix;
   logic        chk_en = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   marker_centroid_if if0 ();
   marker_centroid_if if1 ();

   assign if0.de_in    = de;
   assign if0.hsync_in = hs;
   assign if0.vsync_in = vs;
   assign if0.pixel_in = pix;
   assign if1.de_in    = de;
   assign if1.hsync_in = hs;
   assign if1.vsync_in = vs;
   assign if1.pixel_in = pix;

   marker_centroid u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   marker_centroid #(
      .MIN_PIX (22'd1)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   // ---------------- reference model: frame-level, result scheduled by latency ----------
   typedef struct {
      longint      at;
      int          d;
      logic [31:0] x;
      logic [31:0] y;
      logic        f;
   } ev_t;

   ev_t         pq[$];
   logic [31:0] e_x[2];
   logic [31:0] e_y[2];
   logic        e_valid[2];
   logic        e_found[2];
   logic        e_busy[2];
   longint      busy_last[2];
   int unsigned min_pix[2] = '{16, 1};

   initial begin : model
      longint n;
      int     xp, yp;
      logic   pv, hit, fe;
      longint sx, sy, cnt;
      n = 0; xp = 1; yp = 1; pv = 1'b0; sx = 0; sy = 0; cnt = 0;
      forever begin
         @(posedge clk);
         n++;
         if (rst) begin
            xp = 1; yp = 1; pv = 1'b0; sx = 0; sy = 0; cnt = 0;
            pq.delete();
            for (int d = 0; d < 2; d++) begin
               e_x[d] = 0; e_y[d] = 0; e_valid[d] = 0; e_found[d] = 0; e_busy[d] = 0;
               busy_last[d] = -1;
            end
         end else begin
            for (int d = 0; d < 2; d++) e_valid[d] = 1'b0;
            for (int i = pq.size() - 1; i >= 0; i--) begin
               if (pq[i].at == n) begin
                  e_valid[pq[i].d] = 1'b1;
                  e_found[pq[i].d] = pq[i].f;
                  if (pq[i].f) begin
                     e_x[pq[i].d] = pq[i].x;
                     e_y[pq[i].d] = pq[i].y;
                  end
                  pq.delete(i);
               end
            end
            hit = de && (pix[23:16] >= 8'd200) && (pix[15:8] <= 8'd80) && (pix[7:0] <= 8'd80);
            fe  = vs && !pv;
            if (fe) begin
               for (int d = 0; d < 2; d++) begin
                  if (!e_busy[d]) begin
                     ev_t ev;
                     ev.d = d;
                     if (cnt < longint'(min_pix[d])) begin
                        ev.at = n + 1; ev.f = 1'b0; ev.x = 0; ev.y = 0;
                     end else begin
                        ev.at = n + 65; ev.f = 1'b1;
                        ev.x = 32'(sx / cnt); ev.y = 32'(sy / cnt);
                        busy_last[d] = n + 63;
                     end
                     pq.push_back(ev);
                  end
               end
            end
            for (int d = 0; d < 2; d++) e_busy[d] = (n <= busy_last[d]);
            if (fe) begin
               sx = hit ? xp : 0; sy = hit ? yp : 0; cnt = hit ? 1 : 0;
            end else if (hit) begin
               sx += xp; sy += yp; cnt++;
            end
            if (vs) begin
               xp = 1; yp = 1;
            end else if (hs && xp != 1) begin
               xp = 1; yp++;
            end else if (de) begin
               xp++;
            end
            pv = vs;
         end
      end
   end

   task automatic cmp(input int d, input logic [31:0] ax, input logic [31:0] ay,
                      input logic av, input logic af, input logic ab);
      checks++;
      if ({ax, ay, av, af, ab} !== {e_x[d], e_y[d], e_valid[d], e_found[d], e_busy[d]}) begin
         failures++;
         $display("FAIL cycle_dut%0d at %0t: x=%0d y=%0d valid=%0b found=%0b busy=%0b, required x=%0d y=%0d valid=%0b found=%0b busy=%0b",
                  d, $time, ax, ay, av, af, ab,
                  e_x[d], e_y[d], e_valid[d], e_found[d], e_busy[d]);
      end
   endtask

   initial begin : compare
      forever begin
         @(posedge clk);
         #2;
         if (chk_en) begin
            cmp(0, if0.x, if0.y, if0.valid, if0.found, if0.busy);
            cmp(1, if1.x, if1.y, if1.valid, if1.found, if1.busy);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [23:0] colour(input int mode, input int c, input int r);
      logic [23:0] p;
      p = 24'h202020;
      case (mode)
         0: if (c >= 99 && c <= 103 && r >= 49 && r <= 53) p = 24'hFF0000;
         1: if (r == 5 && (c == 3 || c == 6 || c == 9 || c == 12 || c == 15)) p = 24'hFF0000;
         2: if ((r == 20 && (c == 10 || c == 11)) || (r == 21 && (c == 10 || c == 13)))
               p = 24'hFF0000;
         3: if (r == 3) begin
               if (c == 5)  p = 24'hC85050;
               if (c == 9)  p = 24'hC75050;
               if (c == 13) p = 24'hC85150;
            end
         default: begin
            if ($urandom_range(0, 3) == 0)
               p = {8'($urandom_range(195, 255)), 8'($urandom_range(70, 90)),
                    8'($urandom_range(70, 90))};
            else
               p = 24'($urandom);
         end
      endcase
      return p;
   endfunction

   task automatic drive(input logic d_de, input logic d_hs, input logic d_vs,
                        input logic [23:0] d_pix);
      @(negedge clk);
      de = d_de; hs = d_hs; vs = d_vs; pix = d_pix;
   endtask

   task automatic send_frame(input int mode, input int w, input int h);
      for (int r = 1; r <= h; r++) begin
         for (int c = 1; c <= w; c++) drive(1'b1, 1'b0, 1'b0, colour(mode, c, r));
         drive(1'b0, 1'b0, 1'b0, 24'h0);
         drive(1'b0, 1'b0, 1'b0, 24'h0);
         drive(1'b0, 1'b1, 1'b0, 24'h0);
         drive(1'b0, 1'b0, 1'b0, 24'h0);
      end
   endtask

   // k = cycle index after the frame-end edge cycle at which valid was first seen (0 = never)
   task automatic end_frame_wait(output int k0, output int k1);
      k0 = 0; k1 = 0;
      @(negedge clk);
      de = 1'b0; hs = 1'b0; vs = 1'b1; pix = 24'h0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #2;
         if (k == 2) vs = 1'b0;
         if (if0.valid && k0 == 0) k0 = k;
         if (if1.valid && k1 == 0) k1 = k;
      end
   endtask

   initial begin : stim
      int k0, k1, n0, n1;
      rst = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; pix = 24'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_x", if0.x, 0);
      check("reset_y", if0.y, 0);
      check("reset_valid", if0.valid, 0);
      check("reset_found", if0.found, 0);
      check("reset_busy", if0.busy, 0);

      // 5x5 block centred on (101,51) so the default threshold of 16 is met
      send_frame(0, 106, 55);
      end_frame_wait(k0, k1);
      check("block_latency0", k0, 66);
      check("block_latency1", k1, 66);
      check("block_x", if0.x, 101);
      check("block_y", if0.y, 51);
      check("block_found", if0.found, 1);

      send_frame(1, 24, 8);
      end_frame_wait(k0, k1);
      check("sparse_rej_latency", k0, 2);
      check("sparse_found", if0.found, 0);
      check("sparse_x_held", if0.x, 101);
      check("sparse_y_held", if0.y, 51);
      check("sparse_min1_x", if1.x, 9);
      check("sparse_min1_y", if1.y, 5);

      send_frame(2, 24, 24);
      end_frame_wait(k0, k1);
      check("blob_latency", k1, 66);
      check("blob_x_trunc", if1.x, 11);
      check("blob_y_trunc", if1.y, 20);
      check("blob_found", if1.found, 1);
      check("blob_rej_dut0", k0, 2);

      send_frame(3, 24, 8);
      end_frame_wait(k0, k1);
      check("gate_x", if1.x, 5);
      check("gate_y", if1.y, 3);
      check("gate_found", if1.found, 1);

      // Second frame end 20 cycles into the divide must be ignored
      send_frame(0, 106, 55);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 130; i++) begin
         @(negedge clk);
         vs  = (i < 2) || (i == 20) || (i == 21);
         de  = (i >= 2) && (i <= 19);
         hs  = 1'b0;
         pix = de ? 24'hFF0000 : 24'h0;
         @(posedge clk);
         #2;
         if (i == 10) check("busy_mid_divide", if0.busy, 1);
         if (if0.valid) n0++;
         if (if1.valid) n1++;
      end
      check("busy_edge_valids0", n0, 1);
      check("busy_edge_valids1", n1, 1);
      send_frame(2, 24, 24);
      end_frame_wait(k0, k1);
      check("restart_x", if1.x, 11);
      check("restart_y", if1.y, 20);

      // Reset pulsed while dividing
      send_frame(0, 106, 55);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         vs  = (i < 2);
         rst = (i == 10) || (i == 11);
         de  = 1'b0; hs = 1'b0; pix = 24'h0;
         @(posedge clk);
         #2;
         if (if0.valid) n0++;
         if (if1.valid) n1++;
      end
      check("rst_div_valids0", n0, 0);
      check("rst_div_valids1", n1, 0);
      check("rst_div_x", if0.x, 0);
      check("rst_div_y", if0.y, 0);
      check("rst_div_found", if0.found, 0);
      check("rst_div_busy", if0.busy, 0);
      send_frame(2, 24, 24);
      end_frame_wait(k0, k1);
      check("post_rst_x", if1.x, 11);
      check("post_rst_y", if1.y, 20);

      for (int f = 0; f < 10; f++) begin
         send_frame(4, int'($urandom_range(16, 40)), int'($urandom_range(6, 24)));
         end_frame_wait(k0, k1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
